// File: rtl/rpm_pkg.sv
// Shared types and default constants for the crank-tooth period front end.
// Holds the sequencer state encoding and the default sample width and moving-sum depth.
package rpm_pkg;

    localparam int DEF_LENGTH_INPUT = 16;
    localparam int DEF_COUNT_SUMS   = 16;

    localparam logic [DEF_LENGTH_INPUT-1:0] PERIOD_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } rpm_state_e;

    // States in which the period counter runs and tooth edges are qualified.
    function automatic logic is_tracking(input rpm_state_e s);
        return (s == ST_SYNC) || (s == ST_FILL) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/rpm_period_counter.sv
// Prescaled, saturating tooth-period counter.
// The clear cycle counts as the first prescaler cycle, so count = elapsed_clk / PRESCALE.
module rpm_period_counter
    import rpm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int WIDTH    = DEF_LENGTH_INPUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST    = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_RESTART = PW'(1 % PRESCALE);
    localparam logic [WIDTH-1:0] CNT_MAX     = '1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        count_d = count_q;
        if (clear) begin
            presc_d = PRE_RESTART;
            count_d = '0;
        end else if (en) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == CNT_MAX);

endmodule

// File: rtl/rpm_period_sequencer.sv
// Tooth-period sequencer feeding the RPM moving-sum shift register.
// Qualifies edges, pushes periods, tracks fill state and flushes the chain on stall.
module rpm_period_sequencer
    import rpm_pkg::*;
#(
    parameter int PRESCALE     = 4,
    parameter int LENGTH_INPUT = DEF_LENGTH_INPUT,
    parameter int COUNT_SUMS   = DEF_COUNT_SUMS,
    parameter int MIN_PERIOD   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tooth_edge,
    output logic [LENGTH_INPUT-1:0] sample_out,
    output logic                    sample_en,
    output logic                    sum_valid,
    output logic                    engine_stopped
);

    localparam int FW = $clog2(COUNT_SUMS + 1);
    localparam logic [FW-1:0]           FILL_TARGET = FW'(COUNT_SUMS);
    localparam logic [LENGTH_INPUT-1:0] MIN_COUNT   = LENGTH_INPUT'(MIN_PERIOD);

    rpm_state_e              state_q, state_d;
    logic [FW-1:0]           fill_q, fill_d, fill_next;
    logic [FW-1:0]           flush_q, flush_d;
    logic [LENGTH_INPUT-1:0] sample_q, sample_d;
    logic                    en_q, en_d;
    logic                    valid_q, valid_d;
    logic                    stopped_q, stopped_d;

    logic [LENGTH_INPUT-1:0] count;
    logic                    at_max;
    logic                    tracking;
    logic                    accept;

    assign tracking  = is_tracking(state_q);
    assign accept    = tracking && tooth_edge && (count >= MIN_COUNT);
    assign fill_next = (state_q == ST_SYNC) ? FW'(1) : fill_q + FW'(1);

    // Counter only runs while tracking; an accepted edge restarts it ahead of any tick.
    rpm_period_counter #(
        .PRESCALE (PRESCALE),
        .WIDTH    (LENGTH_INPUT)
    ) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || !tracking),
        .en     (tracking),
        .count  (count),
        .at_max (at_max)
    );

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        flush_d   = flush_q;
        sample_d  = sample_q;
        en_d      = 1'b0;
        valid_d   = valid_q;
        stopped_d = stopped_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tooth_edge) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC, ST_FILL, ST_RUN: begin
                if (accept) begin
                    en_d      = 1'b1;
                    sample_d  = count;
                    stopped_d = 1'b0;
                    if (state_q != ST_RUN) begin
                        fill_d  = fill_next;
                        state_d = (fill_next == FILL_TARGET) ? ST_RUN : ST_FILL;
                        valid_d = (fill_next == FILL_TARGET);
                    end
                end else if (at_max) begin
                    // The first zero strobe is issued from the timeout cycle itself.
                    state_d  = ST_FLUSH;
                    en_d     = 1'b1;
                    sample_d = '0;
                    valid_d  = 1'b0;
                    flush_d  = FW'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_q == FILL_TARGET) begin
                    state_d   = ST_IDLE;
                    stopped_d = 1'b1;
                    flush_d   = '0;
                    fill_d    = '0;
                end else begin
                    en_d     = 1'b1;
                    sample_d = '0;
                    flush_d  = flush_q + FW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            fill_q    <= '0;
            flush_q   <= '0;
            sample_q  <= '0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            stopped_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            flush_q   <= flush_d;
            sample_q  <= sample_d;
            en_q      <= en_d;
            valid_q   <= valid_d;
            stopped_q <= stopped_d;
        end
    end

    assign sample_out     = sample_q;
    assign sample_en      = en_q;
    assign sum_valid      = valid_q;
    assign engine_stopped = stopped_q;

endmodule

// File: doc/rpm_period_sequencer.md
# rpm_period_sequencer

Front-end controller for the RPM moving-sum shift register. It measures tooth-to-tooth periods from a synchronised crank-edge pulse with a prescaled saturating counter and rejects edges that arrive too soon. Each accepted period is pushed into the shift register as a sample with a one-cycle enable. It also tracks when the moving sum is trustworthy, and on a stall timeout it flushes the chain with zeros and reports the engine as stopped.

## Interface
- PRESCALE, 4: clk cycles per period-counter tick (≥1).
- LENGTH_INPUT, 16: sample width. This is also the period counter width.
- COUNT_SUMS, 16: depth of the downstream shift register. It sets the fill count and the flush length.
- MIN_PERIOD, 8: minimum accepted period in ticks. Edges with a smaller count are glitches.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- tooth_edge  in  1  one-cycle pulse per crank tooth, already synchronised to clk.
- sample_out  out  LENGTH_INPUT  sample driven into the shift register's input_sample.
- sample_en  out  1  one-cycle push strobe to the shift register's en.
- sum_valid  out  1  downstream output_sum holds COUNT_SUMS real periods.
- engine_stopped  out  1  no valid tooth stream.

## Operation
- States: IDLE, SYNC, FILL, RUN, FLUSH.
- Period counter: increments once every PRESCALE clk cycles and saturates at 2^LENGTH_INPUT−1 (MAX).
- Accepted edge: tooth_edge=1 with count ≥ MIN_PERIOD. Only SYNC, FILL and RUN apply this test.
- Glitch edge: tooth_edge=1 with count < MIN_PERIOD. It is ignored and the counter keeps running.
- IDLE:
  - engine_stopped=1, counter held at 0.
  - Any tooth_edge → SYNC; clear counter and prescaler.
- SYNC:
  - Accepted edge → push the count as a sample, set fill_cnt=1, → FILL; counter and prescaler cleared.
  - engine_stopped drops to 0 on this first push.
- FILL:
  - Accepted edge → push, fill_cnt+1.
  - When fill_cnt reaches COUNT_SUMS → RUN, sum_valid=1.
- RUN: accepted edge → push.
- Any state with pushes: on each accepted edge the counter restarts at 0. An edge takes priority over a prescale tick in the same cycle.
- Timeout: counter reaching MAX in SYNC, FILL or RUN → FLUSH.
  - sum_valid=0 on entry to FLUSH.
- FLUSH:
  - Exactly COUNT_SUMS consecutive cycles of sample_en=1 with sample_out=0, then → IDLE with engine_stopped=1.
  - tooth_edge is ignored throughout FLUSH, including on its last cycle.
- Arithmetic: no wrap anywhere.
  - fill_cnt is $clog2(COUNT_SUMS+1) bits.
  - The flush counter has the same width.

## Timing
- Reset values: sample_out=0, sample_en=0, sum_valid=0, engine_stopped=1, state=IDLE, counters=0.
- Reset is asynchronous: everything returns to reset values immediately, including mid-FILL or mid-FLUSH.
- Push latency: sample_en and sample_out are registered and appear 1 cycle after the accepted tooth_edge cycle.
  - sample_out holds its value until the next push.
- Sample value: the count as it stood in the edge cycle.
- sum_valid rises in the same cycle as the COUNT_SUMS-th sample_en of FILL.
- Flush strobes start the cycle after the counter hits MAX.
- engine_stopped rises the cycle after the last flush strobe.
- Pushes are at most one per cycle. Back-to-back pushes are impossible outside FLUSH because MIN_PERIOD ≥ 1.

## Structure
- Shared package rpm_pkg holds:
  - the state enum (IDLE/SYNC/FILL/RUN/FLUSH);
  - the default widths and constants: LENGTH_INPUT=16, COUNT_SUMS=16;
  - the period MAX constant.
- Natural sub-module: rpm_period_counter. It contains the prescaler plus the saturating counter, with inputs clear and en and outputs count and at_max.
- The FSM, fill counter and flush counter stay in rpm_period_sequencer.

## Test plan
Defaults for all scenarios: PRESCALE=4, MIN_PERIOD=8, COUNT_SUMS=16.
- Reset: assert reset low mid-simulation → all outputs take reset values in the same cycle. After release, stay IDLE with no strobes.
- Steady stream:
  - Edges every 400 clk → first edge gives no strobe.
  - Every following edge gives sample_en one cycle later with sample_out=100.
  - sum_valid rises with the 16th push.
- Glitch reject: extra edge 20 clk after an accepted edge (count 5) → no strobe. The next edge 400 clk after the accepted one → sample_out=100.
- Timeout: stop edges while in RUN → at count 65535 (≈262140 clk), sum_valid falls. Then 16 strobes with sample_out=0 follow, then engine_stopped=1.
- Edge during FLUSH: pulse tooth_edge on the 5th flush cycle → flush still produces 16 zero strobes and ends in IDLE. The next edge enters SYNC with no strobe.
- Reset mid-FILL after 7 pushes → outputs reset at once. Restart requires SYNC plus 16 fresh pushes before sum_valid=1.
